// File: rtl/regfile_2r1w.sv
// General-purpose register file: one synchronous write port and two registered read ports.
// Register 0 reads as zero, and a write in the same cycle is forwarded to a read of the same register.
module regfile_2r1w #(
   parameter int WIDTH = 32,
   parameter int NREGS = 32,
   parameter int AW    = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re1,
   input  logic [AW-1:0]    raddr1,
   output logic [WIDTH-1:0] rdata1,
   input  logic             re2,
   input  logic [AW-1:0]    raddr2,
   output logic [WIDTH-1:0] rdata2
);

   logic [WIDTH-1:0] regs_q [NREGS];
   logic [WIDTH-1:0] regs_d [NREGS];
   logic [WIDTH-1:0] rdata1_q, rdata1_d;
   logic [WIDTH-1:0] rdata2_q, rdata2_d;
   logic             wr_valid;

   // Next value of one read register.
   // stored is the array entry as it stands before the edge.
   function automatic logic [WIDTH-1:0] read_next(
      input logic             re,
      input logic [AW-1:0]    raddr,
      input logic [WIDTH-1:0] stored,
      input logic [WIDTH-1:0] prev
   );
      logic [WIDTH-1:0] res;
      res = prev;
      if (re) begin
         if (raddr == '0)
            res = '0;
         else if (wr_valid && (waddr == raddr))
            res = wdata;
         else
            res = stored;
      end
      return res;
   endfunction

   assign wr_valid = we && (waddr != '0);

   always_comb begin
      // NOTE: every variable written here is given a default first, so no path leaves it unassigned and no latch is inferred.
      regs_d = regs_q;
      if (wr_valid)
         regs_d[waddr] = wdata;
      regs_d[0] = '0;

      rdata1_d = read_next(re1, raddr1, regs_q[raddr1], rdata1_q);
      rdata2_d = read_next(re2, raddr2, regs_q[raddr2], rdata2_q);
   end

   always_ff @(posedge clk) begin
      // NOTE: the storage array is a flat set of flops, so it can be reset and is, which keeps X off the outputs after the first reset edge.
      if (reset) begin
         regs_q   <= '{default: '0};
         rdata1_q <= '0;
         rdata2_q <= '0;
      end else begin
         // NOTE: non-blocking assignments let every flop here sample values from before the edge.
         regs_q   <= regs_d;
         rdata1_q <= rdata1_d;
         rdata2_q <= rdata2_d;
      end
   end

   assign rdata1 = rdata1_q;
   assign rdata2 = rdata2_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w. The stimulus pushes the expected read data into a scoreboard queue.
// A separate monitor pops each entry on the falling edge and compares it.
module tb_regfile_2r1w;

   localparam int WIDTH = 32;
   localparam int AW    = 5;

   typedef struct {
      string            name;
      logic [WIDTH-1:0] exp1;
      logic [WIDTH-1:0] exp2;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             we;
   logic [AW-1:0]    waddr;
   logic [WIDTH-1:0] wdata;
   logic             re1;
   logic [AW-1:0]    raddr1;
   logic [WIDTH-1:0] rdata1;
   logic             re2;
   logic [AW-1:0]    raddr2;
   logic [WIDTH-1:0] rdata2;

   exp_t sb[$];
   int   n_compared = 0;
   int   n_mismatch = 0;
   bit   stim_done  = 1'b0;

   regfile_2r1w #(.WIDTH(WIDTH), .NREGS(32), .AW(AW)) dut (
      .clk    (clk),
      .reset  (reset),
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
      .re1    (re1),
      .raddr1 (raddr1),
      .rdata1 (rdata1),
      .re2    (re2),
      .raddr2 (raddr2),
      .rdata2 (rdata2)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs, clock it in, and optionally queue the expected outputs for that edge.
   task automatic step(input logic rst, input logic w, input logic [AW-1:0] wa,
                       input logic [WIDTH-1:0] wd,
                       input logic r1, input logic [AW-1:0] a1,
                       input logic r2, input logic [AW-1:0] a2,
                       input bit chk, input logic [WIDTH-1:0] e1,
                       input logic [WIDTH-1:0] e2, input string name);
      exp_t e;
      reset = rst; we = w; waddr = wa; wdata = wd;
      re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
      @(posedge clk);
      if (chk) begin
         e.name = name; e.exp1 = e1; e.exp2 = e2;
         sb.push_back(e);
      end
      #1;
   endtask

   // Monitor: the outputs are compared away from the rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_compared++;
            if (rdata1 !== e.exp1) begin
               n_mismatch++;
               $display("FAIL %s rdata1: got %h expected %h", e.name, rdata1, e.exp1);
            end
            n_compared++;
            if (rdata2 !== e.exp2) begin
               n_mismatch++;
               $display("FAIL %s rdata2: got %h expected %h", e.name, rdata2, e.exp2);
            end
         end
      end
   end

   // Stimulus: directed vectors with hand-computed expectations.
   initial begin
      step(1, 0, 0, 0,            0, 0, 0, 0,   1, 32'h0, 32'h0, "reset_state");
      step(0, 1, 5, 32'hdeadbeef, 0, 0, 0, 0,   0, 32'h0, 32'h0, "");
      step(1, 0, 0, 0,            0, 0, 0, 0,   1, 32'h0, 32'h0, "reset_edge");
      step(0, 0, 0, 0,            1, 5, 1, 5,   1, 32'h0, 32'h0, "reset_clears_r5");

      step(0, 1, 7,  32'h12345678, 0, 0, 0, 0,  1, 32'h0, 32'h0, "idle_hold0");
      step(0, 1, 31, 32'hcafef00d, 0, 0, 0, 0,  0, 32'h0, 32'h0, "");
      step(0, 0, 0, 0,             1, 7, 1, 31, 1, 32'h12345678, 32'hcafef00d, "basic_rd");

      step(0, 1, 0, 32'hffffffff,  1, 0, 0, 0,  1, 32'h0, 32'hcafef00d, "r0_wr_rd");
      step(0, 0, 0, 0,             1, 0, 0, 0,  1, 32'h0, 32'hcafef00d, "r0_rd_next");

      step(0, 1, 3, 32'h00000011,  0, 0, 0, 0,  0, 32'h0, 32'h0, "");
      step(0, 1, 3, 32'h00000022,  1, 3, 1, 3,  1, 32'h22, 32'h22, "fwd_both");
      step(0, 0, 0, 0,             0, 0, 1, 3,  1, 32'h22, 32'h22, "fwd_stored");

      step(0, 0, 0, 0,             1, 7, 0, 0,  1, 32'h12345678, 32'h22, "hold_rd7");
      step(0, 1, 7, 32'h0,         0, 0, 0, 0,  1, 32'h12345678, 32'h22, "hold_wr");
      step(0, 0, 0, 0,             0, 0, 0, 0,  1, 32'h12345678, 32'h22, "hold_idle");
      step(0, 0, 0, 0,             1, 7, 0, 0,  1, 32'h0, 32'h22, "hold_reread");

      step(0, 1, 10, 32'ha5a5a5a5, 0, 0, 0, 0,  0, 32'h0, 32'h0, "");
      step(0, 1, 11, 32'h00000005, 1, 11, 1, 10, 1, 32'h5, 32'ha5a5a5a5, "fwd_one_port");
      step(0, 0, 0, 0,             1, 10, 1, 10, 1, 32'ha5a5a5a5, 32'ha5a5a5a5, "same_addr");

      step(1, 1, 9, 32'habcdabcd,  1, 10, 1, 10, 1, 32'h0, 32'h0, "rst_vs_wr");
      step(0, 0, 0, 0,             1, 9, 1, 11, 1, 32'h0, 32'h0, "rst_discard");

      step(0, 0, 0, 0,             0, 0, 0, 0,  0, 32'h0, 32'h0, "");
      step(0, 0, 0, 0,             0, 0, 0, 0,  0, 32'h0, 32'h0, "");
      stim_done = 1'b1;
   end

   // Final accounting: the scoreboard must have drained.
   initial begin
      fork
         wait (stim_done);
         #100000;
      join_any
      disable fork;
      n_compared++;
      if (!stim_done) begin
         n_mismatch++;
         $display("FAIL timeout: stimulus done=%0d expected 1", stim_done);
      end else if (sb.size() != 0) begin
         n_mismatch++;
         $display("FAIL sb_drain: pending=%0d expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
      $finish;
   end

endmodule
